clock: RTL and testbench
========================

Name: clock

Overview:
- Time-of-day clock block (hours:minutes:seconds) driven from the system clock.
- A parameterised prescaler derives a 1 Hz seconds tick.
- Cascaded seconds/minutes/hours counters wrap at 60/60/24.
- Provides binary and BCD time outputs plus single-cycle rollover pulses for display and alarm logic elsewhere in the design.

Parameters:
- TICKS_PER_SEC, default 10: CLK cycles per second; legal range >= 2.
- PRESC_W, default $clog2(TICKS_PER_SEC): prescaler width; derived, not overridden.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- EN  in  1  count enable; when low, prescaler and time hold.
- LOAD  in  1  synchronous time-set strobe.
- LOAD_HOUR  in  5  hour to load, 0..23.
- LOAD_MIN  in  6  minute to load, 0..59.
- LOAD_SEC  in  6  second to load, 0..59.
- SEC  out  6  current seconds, binary.
- MIN  out  6  current minutes, binary.
- HOUR  out  5  current hours, binary.
- SEC_BCD  out  8  seconds, tens in [7:4], units in [3:0].
- MIN_BCD  out  8  minutes, BCD.
- HOUR_BCD  out  8  hours, BCD.
- SEC_TICK  out  1  one-cycle pulse per elapsed second.
- MIN_TICK  out  1  one-cycle pulse when seconds wrap 59->0.
- HOUR_TICK  out  1  one-cycle pulse when minutes wrap 59->0.
- DAY_TICK  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
- LOAD_ERR  out  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset (RST=1, asynchronous):
  - prescaler, SEC, MIN, HOUR = 0.
  - all *_TICK = 0; LOAD_ERR = 0.
  - Takes effect immediately, including mid-count or mid-load.
- Priority per edge: RST > valid LOAD > counting.
- Valid LOAD (LOAD=1, LOAD_HOUR<=23, LOAD_MIN<=59, LOAD_SEC<=59):
  - time registers take the load values.
  - prescaler cleared to 0.
  - all ticks low next cycle, independent of EN.
- Invalid LOAD (any field out of range):
  - time registers unchanged; LOAD_ERR=1 for exactly the next cycle.
  - counting proceeds as if LOAD=0.
- Counting with EN=1:
  - prescaler increments each edge.
  - At the edge where prescaler == TICKS_PER_SEC-1: prescaler -> 0, SEC increments, SEC_TICK registered high for the following cycle.
  - SEC==59 at that edge: SEC -> 0, MIN increments, MIN_TICK high with SEC_TICK.
  - MIN==59 as well: MIN -> 0, HOUR increments, HOUR_TICK high.
  - HOUR==23 as well: HOUR -> 0, DAY_TICK high.
  - All ticks asserted together on a full rollover.
- EN=0: all state holds; ticks low. Deasserting EN does not clear the prescaler.
- Ticks are registered: high exactly one CLK cycle, low otherwise.
- BCD outputs: combinational from the binary registers, zero latency; unused upper tens bits are 0.
- Counters never hold out-of-range values.

Decomposition:
- Package clock_pkg:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - time_t struct {hour[4:0], min[5:0], sec[5:0]}.
  - bcd8_t typedef.
- One sub-module, bin2bcd: 6-bit binary 0..59 to 8-bit BCD, purely combinational, instantiated three times.

Test Plan:
- Reset: assert RST mid-count at 00:00:07 -> all outputs 0 immediately, asynchronously; counting resumes from 00:00:00 after release with EN=1.
- Prescaler: EN=1, TICKS_PER_SEC=10 -> SEC_TICK high 1 cycle every 10 CLK; SEC 0->1 at 10th edge; SEC_BCD=8'h01.
- Cascade: LOAD 23:59:59, then run 10 cycles -> time 00:00:00; SEC/MIN/HOUR/DAY_TICK all high the same single cycle.
- Invalid load: LOAD with LOAD_MIN=60 at 12:34:56 -> time unchanged, LOAD_ERR pulse 1 cycle, counting continues.
- EN hold: EN=0 for 25 cycles at 01:02:03 with prescaler=4 -> no change, no ticks; EN=1 -> SEC_TICK after 6 cycles.
- BCD check: LOAD 19:45:38 -> HOUR_BCD=8'h19, MIN_BCD=8'h45, SEC_BCD=8'h38 the cycle after load.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, limits and payload types for the time-of-day clock.
package clock_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned BCD_W  = 8;

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  typedef logic [BCD_W-1:0] bcd8_t;

  typedef struct packed {
    logic day;
    logic hour;
    logic min;
    logic sec;
  } tick_t;

endpackage

// File: rtl/clock_bin2bcd.sv
// Combinational 0..59 binary to two-digit BCD; tens digit uses bits [6:4], bit 7 is 0.
module bin2bcd
  import clock_pkg::*;
(
  input  logic [5:0] bin_i,
  output bcd8_t      bcd_o
);

  logic [2:0] tens;
  logic [3:0] units;

  // Range-compare ladder; inputs above 59 never occur.
  always_comb begin
    tens  = 3'd0;
    units = 4'(bin_i);
    if (bin_i >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin_i - 6'd50);
    end else if (bin_i >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin_i - 6'd40);
    end else if (bin_i >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin_i - 6'd30);
    end else if (bin_i >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin_i - 6'd20);
    end else if (bin_i >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin_i - 6'd10);
    end
  end

  assign bcd_o = {1'b0, tens, units};

endmodule

// File: rtl/clock.sv
// Time-of-day clock: prescaled 1 Hz tick feeding cascaded sec/min/hour counters,
// with synchronous validated time load, rollover pulses and BCD views.
module clock
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [HOUR_W-1:0] LOAD_HOUR,
  input  logic [MIN_W-1:0]  LOAD_MIN,
  input  logic [SEC_W-1:0]  LOAD_SEC,
  output logic [SEC_W-1:0]  SEC,
  output logic [MIN_W-1:0]  MIN,
  output logic [HOUR_W-1:0] HOUR,
  output bcd8_t             SEC_BCD,
  output bcd8_t             MIN_BCD,
  output bcd8_t             HOUR_BCD,
  output logic              SEC_TICK,
  output logic              MIN_TICK,
  output logic              HOUR_TICK,
  output logic              DAY_TICK,
  output logic              LOAD_ERR
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  time_t              time_q, time_d;
  tick_t              tick_q, tick_d;
  logic               load_err_q, load_err_d;
  logic               load_ok;
  logic               presc_wrap;

  assign load_ok = LOAD && (LOAD_HOUR <= HOUR_MAX) && (LOAD_MIN <= MIN_MAX)
                        && (LOAD_SEC <= SEC_MAX);
  assign presc_wrap = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q    <= '0;
      time_q     <= '0;
      tick_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      time_q     <= time_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Valid load wins over counting; a rejected load only flags an error.
  always_comb begin
    presc_d    = presc_q;
    time_d     = time_q;
    tick_d     = '0;
    load_err_d = 1'b0;
    if (load_ok) begin
      time_d.hour = LOAD_HOUR;
      time_d.min  = LOAD_MIN;
      time_d.sec  = LOAD_SEC;
      presc_d     = '0;
    end else begin
      load_err_d = LOAD;
      if (EN) begin
        if (presc_wrap) begin
          presc_d    = '0;
          tick_d.sec = 1'b1;
          if (time_q.sec >= SEC_MAX) begin
            time_d.sec = '0;
            tick_d.min = 1'b1;
            if (time_q.min >= MIN_MAX) begin
              time_d.min  = '0;
              tick_d.hour = 1'b1;
              if (time_q.hour >= HOUR_MAX) begin
                time_d.hour = '0;
                tick_d.day  = 1'b1;
              end else begin
                time_d.hour = time_q.hour + HOUR_W'(1);
              end
            end else begin
              time_d.min = time_q.min + MIN_W'(1);
            end
          end else begin
            time_d.sec = time_q.sec + SEC_W'(1);
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
    end
  end

  assign SEC       = time_q.sec;
  assign MIN       = time_q.min;
  assign HOUR      = time_q.hour;
  assign SEC_TICK  = tick_q.sec;
  assign MIN_TICK  = tick_q.min;
  assign HOUR_TICK = tick_q.hour;
  assign DAY_TICK  = tick_q.day;
  assign LOAD_ERR  = load_err_q;

  bin2bcd u_sec_bcd  (.bin_i(time_q.sec),         .bcd_o(SEC_BCD));
  bin2bcd u_min_bcd  (.bin_i(time_q.min),         .bcd_o(MIN_BCD));
  bin2bcd u_hour_bcd (.bin_i({1'b0, time_q.hour}), .bcd_o(HOUR_BCD));

endmodule

// File: tb/tb_clock.sv
// Directed bench for the time-of-day clock at TICKS_PER_SEC=10.
module tb_clock;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       LOAD;
  logic [4:0] LOAD_HOUR;
  logic [5:0] LOAD_MIN;
  logic [5:0] LOAD_SEC;
  logic [5:0] SEC;
  logic [5:0] MIN;
  logic [4:0] HOUR;
  logic [7:0] SEC_BCD;
  logic [7:0] MIN_BCD;
  logic [7:0] HOUR_BCD;
  logic       SEC_TICK;
  logic       MIN_TICK;
  logic       HOUR_TICK;
  logic       DAY_TICK;
  logic       LOAD_ERR;

  int checks = 0;
  int errors = 0;

  clock #(.TICKS_PER_SEC(10)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD),
    .LOAD_HOUR(LOAD_HOUR), .LOAD_MIN(LOAD_MIN), .LOAD_SEC(LOAD_SEC),
    .SEC(SEC), .MIN(MIN), .HOUR(HOUR),
    .SEC_BCD(SEC_BCD), .MIN_BCD(MIN_BCD), .HOUR_BCD(HOUR_BCD),
    .SEC_TICK(SEC_TICK), .MIN_TICK(MIN_TICK), .HOUR_TICK(HOUR_TICK),
    .DAY_TICK(DAY_TICK), .LOAD_ERR(LOAD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 8'(HOUR), 8'(h));
    chk({tag, ".min"},  8'(MIN),  8'(m));
    chk({tag, ".sec"},  8'(SEC),  8'(s));
  endtask

  // Expected pattern is {DAY, HOUR, MIN, SEC}.
  task automatic chk_ticks(input string tag, input logic [3:0] exp);
    chk({tag, ".ticks"}, 8'({DAY_TICK, HOUR_TICK, MIN_TICK, SEC_TICK}), 8'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    LOAD      = 1'b1;
    LOAD_HOUR = 5'(h);
    LOAD_MIN  = 6'(m);
    LOAD_SEC  = 6'(s);
    cyc(1);
    LOAD      = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0;
    LOAD_HOUR = '0; LOAD_MIN = '0; LOAD_SEC = '0;
    cyc(2);
    chk_time("reset", 0, 0, 0);
    chk_ticks("reset", 4'b0000);
    chk("reset.err", 8'(LOAD_ERR), 8'd0);

    // Prescaler: first second after 10 edges
    RST = 1'b0; EN = 1'b1;
    cyc(9);
    chk_time("presc9", 0, 0, 0);
    chk_ticks("presc9", 4'b0000);
    cyc(1);
    chk_time("presc10", 0, 0, 1);
    chk_ticks("presc10", 4'b0001);
    chk("presc10.sec_bcd", SEC_BCD, 8'h01);
    cyc(1);
    chk_ticks("presc11", 4'b0000);

    // Run to 00:00:07, then async reset mid-count
    cyc(59);
    chk_time("run7", 0, 0, 7);
    cyc(3);
    #2 RST = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst.sec_bcd", SEC_BCD, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    cyc(9);
    chk_time("post_rst9", 0, 0, 0);
    cyc(1);
    chk_time("post_rst10", 0, 0, 1);
    chk_ticks("post_rst10", 4'b0001);

    // Reset while a tick is high clears it immediately
    #2 RST = 1'b1;
    #1;
    chk_ticks("rst_tick", 4'b0000);
    chk_time("rst_tick", 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Full cascade rollover
    do_load(23, 59, 59);
    chk_time("casc_load", 23, 59, 59);
    chk_ticks("casc_load", 4'b0000);
    cyc(9);
    chk_time("casc9", 23, 59, 59);
    chk_ticks("casc9", 4'b0000);
    cyc(1);
    chk_time("casc10", 0, 0, 0);
    chk_ticks("casc10", 4'b1111);
    chk("casc10.hour_bcd", HOUR_BCD, 8'h00);
    cyc(1);
    chk_ticks("casc11", 4'b0000);

    // Invalid load (minute 60) leaves time alone, counting continues
    do_load(12, 34, 56);
    cyc(2);
    do_load(12, 60, 0);
    chk("inv.err", 8'(LOAD_ERR), 8'd1);
    chk_time("inv", 12, 34, 56);
    cyc(1);
    chk("inv.err_clr", 8'(LOAD_ERR), 8'd0);
    cyc(5);
    chk_time("inv_run", 12, 34, 56);
    cyc(1);
    chk_time("inv_tick", 12, 34, 57);
    chk_ticks("inv_tick", 4'b0001);
    do_load(24, 0, 0);
    chk("inv_hour.err", 8'(LOAD_ERR), 8'd1);
    chk_time("inv_hour", 12, 34, 57);

    // EN hold with prescaler at 4
    do_load(1, 2, 3);
    cyc(4);
    EN = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      chk_time("hold", 1, 2, 3);
      chk_ticks("hold", 4'b0000);
    end
    EN = 1'b1;
    cyc(5);
    chk_ticks("resume5", 4'b0000);
    cyc(1);
    chk_time("resume6", 1, 2, 4);
    chk_ticks("resume6", 4'b0001);

    // BCD view, load accepted with EN low
    EN = 1'b0;
    do_load(19, 45, 38);
    chk_time("bcd", 19, 45, 38);
    chk("bcd.hour", HOUR_BCD, 8'h19);
    chk("bcd.min",  MIN_BCD,  8'h45);
    chk("bcd.sec",  SEC_BCD,  8'h38);
    cyc(3);
    chk_time("bcd_hold", 19, 45, 38);

    // Hour rollover without day rollover
    EN = 1'b1;
    do_load(10, 59, 59);
    cyc(10);
    chk_time("hour_roll", 11, 0, 0);
    chk_ticks("hour_roll", 4'b0111);
    chk("hour_roll.hour_bcd", HOUR_BCD, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
